// File: rtl/trig_sequencer_if.sv
// trig_sequencer control/status bundle.
// Control side drives requests, sequencer drives trigger pins and status.
interface trig_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              en;
  logic              mode;
  logic              start;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] trig;
  logic [IDX_W-1:0]  ch_idx;
  logic              busy;
  logic              sweep_done;

  modport master (
    output en, mode, start, ch_mask,
    input  trig, ch_idx, busy, sweep_done
  );

  modport slave (
    input  en, mode, start, ch_mask,
    output trig, ch_idx, busy, sweep_done
  );
endinterface

// File: rtl/trig_sequencer.sv
// Multi-channel trigger-pulse sequencer for ultrasonic sensor arrays.
// Fires a fixed-width pulse per enabled channel, each followed by a gap.
module trig_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int TRIG_CYCLES = 60,
  parameter int GAP_CYCLES  = 12000,
  parameter int CNT_W       = 16,
  parameter int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic            clk,
  input logic            rst_n,
  trig_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRIG,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] trig_q, trig_d;
  logic [NUM_CH-1:0] above;
  logic              any_set;
  logic              has_above;

  function automatic logic [IDX_W-1:0] low_bit(input logic [NUM_CH-1:0] m);
    low_bit = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) low_bit = IDX_W'(i);
  endfunction

  // Mask bits strictly above the channel being served
  always_comb begin
    above = '0;
    for (int i = 0; i < NUM_CH; i++)
      above[i] = bus.ch_mask[i] && (i > int'(idx_q));
  end

  assign any_set   = |bus.ch_mask;
  assign has_above = |above;

  // Next-state, counter, channel and status decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.en && (bus.mode || bus.start) && any_set) begin
          state_d = S_TRIG;
          idx_d   = low_bit(bus.ch_mask);
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!bus.en) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else if (has_above) begin
            state_d = S_TRIG;
            idx_d   = low_bit(above);
          end else begin
            done_d = 1'b1;
            if (bus.mode && any_set) begin
              state_d = S_TRIG;
              idx_d   = low_bit(bus.ch_mask);
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    trig_d = (state_d == S_TRIG) ? (NUM_CH'(1) << idx_d) : '0;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      trig_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      trig_q  <= trig_d;
    end
  end

  assign bus.trig       = trig_q;
  assign bus.ch_idx     = idx_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = done_q;

endmodule

// File: tb/tb_trig_sequencer.sv
// Scoreboard bench for trig_sequencer.
// Expected per-cycle outputs are queued from sweep timing, then compared.
module tb_trig_sequencer;

  logic clk;
  logic rst_n;

  trig_sequencer_if #(.NUM_CH(4)) bus ();

  trig_sequencer #(
    .NUM_CH(4),
    .TRIG_CYCLES(3),
    .GAP_CYCLES(5),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] trig;
    logic       busy;
    logic       done;
    int         idx;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] t, input logic b,
                      input logic d, input int idx);
    exp_t e;
    e.trig = t;
    e.busy = b;
    e.done = d;
    e.idx  = idx;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(4'b0, 1'b0, 1'b0, -1);
  endtask

  // n sweeps of 3 high + 5 low per set bit, ascending channel order
  task automatic push_sweeps(input logic [3:0] m, input int n,
                             input bit first_done, input bit tail);
    for (int s = 0; s < n; s++) begin
      bit first;
      first = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (m[c]) begin
          for (int k = 0; k < 3; k++)
            push(4'(1) << c, 1'b1,
                 (k == 0) && first && (s > 0 || first_done), c);
          for (int k = 0; k < 5; k++)
            push(4'b0, 1'b1, 1'b0, c);
          first = 1'b0;
        end
      end
    end
    if (tail) push(4'b0, 1'b0, 1'b1, -1);
  endtask

  task automatic run(input string tag, input int n, input int start_cyc);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_empty obs=nothing exp=queued", tag);
      end else begin
        e = q.pop_front();
        chk(tag, 32'({bus.trig, bus.busy, bus.sweep_done}),
            32'({e.trig, e.busy, e.done}));
        if (e.idx >= 0) chk({tag, "_idx"}, 32'(bus.ch_idx), e.idx);
      end
      bus.start = (i == start_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.en      = 1'b1;
    bus.mode    = 1'b0;
    bus.start   = 1'b0;
    bus.ch_mask = 4'b0;

    #3;
    chk("rst_trig", 32'(bus.trig), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.sweep_done), 0);
    chk("rst_idx", 32'(bus.ch_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-shot sweep, extra start during the sweep is ignored
    @(negedge clk);
    bus.ch_mask = 4'b1011;
    bus.start   = 1'b1;
    push_sweeps(4'b1011, 1, 1'b0, 1'b1);
    idle(3);
    run("oneshot", q.size(), 12);

    // Empty mask drops the request
    @(negedge clk);
    bus.ch_mask = 4'b0000;
    bus.start   = 1'b1;
    idle(4);
    run("empty", q.size(), -1);

    // Continuous single channel, then mode dropped mid-sweep
    @(negedge clk);
    bus.ch_mask = 4'b0001;
    bus.mode    = 1'b1;
    push_sweeps(4'b0001, 4, 1'b0, 1'b0);
    push_sweeps(4'b0001, 1, 1'b1, 1'b1);
    idle(2);
    run("cont", 34, -1);
    bus.mode = 1'b0;
    run("cont", q.size(), -1);

    // Enable dropped one cycle into the first pulse
    @(negedge clk);
    bus.ch_mask = 4'b0011;
    bus.start   = 1'b1;
    for (int k = 0; k < 3; k++) push(4'b0001, 1'b1, 1'b0, 0);
    for (int k = 0; k < 5; k++) push(4'b0000, 1'b1, 1'b0, 0);
    idle(3);
    run("endrop", 1, -1);
    bus.en = 1'b0;
    run("endrop", q.size(), -1);
    bus.en = 1'b1;

    // Channel 3 removed during channel 1's pulse
    @(negedge clk);
    bus.ch_mask = 4'b1011;
    bus.start   = 1'b1;
    push_sweeps(4'b0011, 1, 1'b0, 1'b1);
    idle(2);
    run("maskedit", 9, -1);
    bus.ch_mask = 4'b0011;
    run("maskedit", q.size(), -1);

    // Async reset mid-pulse, then continuous restart
    @(negedge clk);
    bus.ch_mask = 4'b0110;
    bus.mode    = 1'b1;
    push_sweeps(4'b0110, 1, 1'b0, 1'b0);
    run("rst_pre", 10, -1);
    q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_trig", 32'(bus.trig), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.sweep_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_sweeps(4'b0110, 2, 1'b0, 1'b0);
    run("rst_post", q.size(), -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
